// File: rtl/uart_rx_deserializer_pkg.sv
// UartGlobalPkg: shared types and constants for the UART receive path.
package UartGlobalPkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam logic        START_BIT  = 1'b0;
    localparam logic        STOP_BIT   = 1'b1;

    typedef enum logic [3:0] {
        DATA_BITS_5 = 4'd5,
        DATA_BITS_6 = 4'd6,
        DATA_BITS_7 = 4'd7,
        DATA_BITS_8 = 4'd8
    } dataTypeEnum;

    typedef enum logic [1:0] {
        STOP_BITS_1 = 2'd1,
        STOP_BITS_2 = 2'd2
    } stopBitEnum;

    typedef enum logic [2:0] {
        IDLE,
        STARTBIT,
        DATA,
        PARITY,
        STOP,
        LINEWAIT
    } UartReceiverStateEnum;

    // Out-of-range data-bit settings fall back to 8 bits.
    function automatic dataTypeEnum decodeDataBits(input logic [3:0] cfg);
        case (cfg)
            4'd5:    return DATA_BITS_5;
            4'd6:    return DATA_BITS_6;
            4'd7:    return DATA_BITS_7;
            default: return DATA_BITS_8;
        endcase
    endfunction

    // Anything other than 2 means a single stop bit.
    function automatic stopBitEnum decodeStopBits(input logic [1:0] cfg);
        return (cfg == 2'd2) ? STOP_BITS_2 : STOP_BITS_1;
    endfunction

endpackage

// File: rtl/uart_rx_deserializer_bit_timer.sv
// uart_rx_bit_timer: sampleTick counter within a bit plus bit-position counter.
module uart_rx_bit_timer #(
    parameter int unsigned OVERSAMPLING = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            sampleTick,
    input  logic                            restart,
    input  logic                            nextBit,
    output logic [$clog2(OVERSAMPLING)-1:0] tickCount,
    output logic [3:0]                      bitCount
);

    // Count ticks; restart clears both counters, nextBit moves to the next bit slot.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tickCount <= '0;
            bitCount  <= '0;
        end else if (sampleTick) begin
            if (restart) begin
                tickCount <= '0;
                bitCount  <= '0;
            end else if (nextBit) begin
                tickCount <= '0;
                bitCount  <= bitCount + 4'd1;
            end else begin
                tickCount <= tickCount + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: oversampled UART receiver with handshake output.
// Optional build macro UART_RX_MAJORITY_VOTE_EN: 2-of-3 vote per data/parity/stop bit.
module uart_rx_deserializer #(
    parameter int unsigned DATA_WIDTH   = UartGlobalPkg::DATA_WIDTH,
    parameter int unsigned OVERSAMPLING = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sampleTick,
    input  logic                  rx,
    input  logic [3:0]            cfgDataBits,
    input  logic                  cfgParityEnable,
    input  logic                  cfgParityOdd,
    input  logic [1:0]            cfgStopBits,
    output logic [DATA_WIDTH-1:0] rxData,
    output logic                  rxValid,
    input  logic                  rxReady,
    output logic                  parityError,
    output logic                  framingError,
    output logic                  breakError,
    output logic                  overrunError,
    output logic                  busy
);
    import UartGlobalPkg::*;

    localparam int unsigned CW = $clog2(OVERSAMPLING);

    logic                  rxMeta, rxSync;
    UartReceiverStateEnum  state, nextState;
    logic [CW-1:0]         tickCount;
    logic [3:0]            bitCount;
    logic                  restart, nextBit, startConfirm, frameDone;
    logic                  halfPoint, samplePoint, bitValue;
    logic                  lastDataBit, lastStopBit, firstStopLow;
    logic [DATA_WIDTH-1:0] shiftReg;
    dataTypeEnum           dataBitsLat;
    stopBitEnum            stopBitsLat;
    logic                  parityEnLat, parityOddLat;
    logic                  parityAcc, allZero, stopZero, firstStopZero;
    int unsigned           alignShift;

    uart_rx_bit_timer #(.OVERSAMPLING(OVERSAMPLING)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .sampleTick (sampleTick),
        .restart    (restart),
        .nextBit    (nextBit),
        .tickCount  (tickCount),
        .bitCount   (bitCount)
    );

    assign halfPoint   = (tickCount == CW'(OVERSAMPLING / 2 - 1));
    assign samplePoint = (tickCount == CW'(OVERSAMPLING - 1));
    assign lastDataBit = (bitCount == dataBitsLat - 4'd1);
    assign lastStopBit = (stopBitsLat == STOP_BITS_2) ? (bitCount == 4'd1) : 1'b1;
    assign alignShift  = DATA_WIDTH - 32'(dataBitsLat);

    // Two-flop synchronizer on the asynchronous serial line (idle high).
    always_ff @(posedge clk) begin
        if (!reset) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
        end else begin
            rxMeta <= rx;
            rxSync <= rxMeta;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic voteA, voteB;

    // Capture the two early votes ahead of the mid-bit decision point.
    always_ff @(posedge clk) begin
        if (!reset) begin
            voteA <= 1'b1;
            voteB <= 1'b1;
        end else if (sampleTick) begin
            if (tickCount == CW'(OVERSAMPLING - 3)) voteA <= rxSync;
            if (tickCount == CW'(OVERSAMPLING - 2)) voteB <= rxSync;
        end
    end

    assign bitValue = (voteA & voteB) | (voteA & rxSync) | (voteB & rxSync);
`else
    assign bitValue = rxSync;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    // Next-state logic; every transition is qualified by sampleTick.
    always_comb begin
        nextState = state;
        if (sampleTick) begin
            case (state)
                IDLE:     if (rxSync == START_BIT) nextState = STARTBIT;
                STARTBIT: if (halfPoint) nextState = (rxSync == START_BIT) ? DATA : IDLE;
                DATA:     if (samplePoint && lastDataBit) nextState = parityEnLat ? PARITY : STOP;
                PARITY:   if (samplePoint) nextState = STOP;
                STOP:     if (samplePoint && lastStopBit)
                              nextState = (bitValue == STOP_BIT) ? IDLE : LINEWAIT;
                LINEWAIT: if (rxSync == STOP_BIT) nextState = IDLE;
                default:  nextState = IDLE;
            endcase
        end
    end

    // Timer control, start confirmation and frame-complete strobes.
    always_comb begin
        restart      = 1'b0;
        nextBit      = 1'b0;
        startConfirm = 1'b0;
        frameDone    = 1'b0;
        busy         = (state != IDLE);
        if (sampleTick) begin
            case (state)
                IDLE, LINEWAIT: restart = 1'b1;
                STARTBIT: if (halfPoint) begin
                    restart      = 1'b1;
                    startConfirm = (rxSync == START_BIT);
                end
                DATA: if (samplePoint) begin
                    restart = lastDataBit;
                    nextBit = !lastDataBit;
                end
                PARITY: if (samplePoint) restart = 1'b1;
                STOP: if (samplePoint) begin
                    restart   = lastStopBit;
                    nextBit   = !lastStopBit;
                    frameDone = lastStopBit;
                end
                default: restart = 1'b1;
            endcase
        end
    end

    // Frame datapath: cfg latch at start confirm, then shift/accumulate per sampled bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            shiftReg      <= '0;
            dataBitsLat   <= DATA_BITS_8;
            stopBitsLat   <= STOP_BITS_1;
            parityEnLat   <= 1'b0;
            parityOddLat  <= 1'b0;
            parityAcc     <= 1'b0;
            allZero       <= 1'b0;
            stopZero      <= 1'b0;
            firstStopZero <= 1'b0;
        end else if (startConfirm) begin
            shiftReg      <= '0;
            dataBitsLat   <= decodeDataBits(cfgDataBits);
            stopBitsLat   <= decodeStopBits(cfgStopBits);
            parityEnLat   <= cfgParityEnable;
            parityOddLat  <= cfgParityOdd;
            parityAcc     <= 1'b0;
            allZero       <= 1'b1;
            stopZero      <= 1'b0;
            firstStopZero <= 1'b0;
        end else if (sampleTick && samplePoint) begin
            case (state)
                DATA: begin
                    shiftReg  <= {bitValue, shiftReg[DATA_WIDTH-1:1]};
                    parityAcc <= parityAcc ^ bitValue;
                    allZero   <= allZero & ~bitValue;
                end
                PARITY: begin
                    parityAcc <= parityAcc ^ bitValue;
                    allZero   <= allZero & ~bitValue;
                end
                STOP: begin
                    stopZero <= stopZero | ~bitValue;
                    if (bitCount == 4'd0) firstStopZero <= ~bitValue;
                end
                default: ;
            endcase
        end
    end

    // The first stop bit may be the one being sampled right now (single-stop frames).
    assign firstStopLow = (bitCount == 4'd0) ? ~bitValue : firstStopZero;

    // Output register and rxValid/rxReady handshake; a new frame wins over a same-edge handshake.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rxData       <= '0;
            rxValid      <= 1'b0;
            parityError  <= 1'b0;
            framingError <= 1'b0;
            breakError   <= 1'b0;
            overrunError <= 1'b0;
        end else if (frameDone) begin
            // Bits were shifted in at the MSB; realign so bit 0 lands at the LSB.
            rxData       <= shiftReg >> alignShift;
            rxValid      <= 1'b1;
            parityError  <= parityEnLat & (parityAcc != parityOddLat);
            framingError <= stopZero | ~bitValue;
            breakError   <= allZero & firstStopLow;
            overrunError <= rxValid & ~rxReady;
        end else if (rxValid && rxReady) begin
            rxValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed testbench for uart_rx_deserializer (8-bit, 16x oversampling).
module tb_uart_rx_deserializer;

    localparam int unsigned TICK_DIV   = 4;
    localparam int unsigned BIT_CYCLES = 16 * TICK_DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sampleTick = 1'b0;
    logic       rx = 1'b1;
    logic [3:0] cfgDataBits = 4'd8;
    logic       cfgParityEnable = 1'b0;
    logic       cfgParityOdd = 1'b0;
    logic [1:0] cfgStopBits = 2'd1;
    logic [7:0] rxData;
    logic       rxValid;
    logic       rxReady = 1'b1;
    logic       parityError, framingError, breakError, overrunError, busy;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    int unsigned validRises = 0;
    int unsigned validHigh = 0;
    logic        prevValid = 1'b0;
    logic [7:0]  capData = '0;
    logic        capPar = 1'b0, capFrm = 1'b0, capBrk = 1'b0, capOvr = 1'b0;
    logic [1:0]  tickDiv = '0;
    int unsigned r0, h0;

    uart_rx_deserializer #(.DATA_WIDTH(8), .OVERSAMPLING(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .sampleTick      (sampleTick),
        .rx              (rx),
        .cfgDataBits     (cfgDataBits),
        .cfgParityEnable (cfgParityEnable),
        .cfgParityOdd    (cfgParityOdd),
        .cfgStopBits     (cfgStopBits),
        .rxData          (rxData),
        .rxValid         (rxValid),
        .rxReady         (rxReady),
        .parityError     (parityError),
        .framingError    (framingError),
        .breakError      (breakError),
        .overrunError    (overrunError),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // One sampleTick every TICK_DIV clocks, changed away from the rising edge.
    always @(negedge clk) begin
        tickDiv    = tickDiv + 2'd1;
        sampleTick = (tickDiv == 2'd0);
    end

    // Output monitor: counts rxValid pulses/cycles and keeps the last delivered word.
    always @(negedge clk) begin
        if (rxValid) begin
            validHigh = validHigh + 1;
            capData   = rxData;
            capPar    = parityError;
            capFrm    = framingError;
            capBrk    = breakError;
            capOvr    = overrunError;
        end
        if (rxValid && !prevValid) validRises = validRises + 1;
        prevValid = rxValid;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sendBit(input logic b);
        rx = b;
        waitCycles(BIT_CYCLES);
    endtask

    // Start, LSB-first data, optional parity, stop bits, then one idle bit.
    // scramble changes every cfg input right after the start bit.
    task automatic sendFrame(input logic [7:0] data, input int unsigned nbits, input logic parEn,
                             input logic parBit, input int unsigned nstop, input logic scramble);
        logic [7:0] d;
        logic [3:0] sDb;
        logic       sPe, sPo;
        logic [1:0] sSb;
        d   = data;
        sDb = cfgDataBits;
        sPe = cfgParityEnable;
        sPo = cfgParityOdd;
        sSb = cfgStopBits;
        sendBit(1'b0);
        if (scramble) begin
            cfgDataBits     = 4'd5;
            cfgParityEnable = 1'b1;
            cfgParityOdd    = 1'b1;
            cfgStopBits     = 2'd2;
        end
        for (int unsigned i = 0; i < nbits; i++) begin
            sendBit(d[0]);
            d = d >> 1;
        end
        if (parEn) sendBit(parBit);
        for (int unsigned i = 0; i < nstop; i++) sendBit(1'b1);
        cfgDataBits     = sDb;
        cfgParityEnable = sPe;
        cfgParityOdd    = sPo;
        cfgStopBits     = sSb;
        sendBit(1'b1);
    endtask

    initial begin
        // Reset state
        waitCycles(5);
        reset = 1'b1;
        waitCycles(1);
        check("rst_data", 32'(rxData), 32'h00);
        check("rst_valid", 32'(rxValid), 32'd0);
        check("rst_par", 32'(parityError), 32'd0);
        check("rst_frm", 32'(framingError), 32'd0);
        check("rst_brk", 32'(breakError), 32'd0);
        check("rst_ovr", 32'(overrunError), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        waitCycles(BIT_CYCLES);

        // 8N1 0xA5
        r0 = validRises;
        h0 = validHigh;
        sendFrame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b0);
        check("a5_pulses", 32'(validRises - r0), 32'd1);
        check("a5_high_cycles", 32'(validHigh - h0), 32'd1);
        check("a5_data", 32'(capData), 32'hA5);
        check("a5_par", 32'(capPar), 32'd0);
        check("a5_frm", 32'(capFrm), 32'd0);
        check("a5_brk", 32'(capBrk), 32'd0);
        check("a5_ovr", 32'(capOvr), 32'd0);
        check("a5_busy_after", 32'(busy), 32'd0);

        // 7E2 0x41, wrong then correct parity bit
        cfgDataBits     = 4'd7;
        cfgParityEnable = 1'b1;
        cfgParityOdd    = 1'b0;
        cfgStopBits     = 2'd2;
        r0 = validRises;
        sendFrame(8'h41, 7, 1'b1, 1'b1, 2, 1'b0);
        check("7e2_p1_pulses", 32'(validRises - r0), 32'd1);
        check("7e2_p1_data", 32'(capData), 32'h41);
        check("7e2_p1_par", 32'(capPar), 32'd1);
        check("7e2_p1_frm", 32'(capFrm), 32'd0);
        sendFrame(8'h41, 7, 1'b1, 1'b0, 2, 1'b0);
        check("7e2_p0_pulses", 32'(validRises - r0), 32'd2);
        check("7e2_p0_data", 32'(capData), 32'h41);
        check("7e2_p0_par", 32'(capPar), 32'd0);

        // False start: 3 ticks low
        cfgDataBits     = 4'd8;
        cfgParityEnable = 1'b0;
        cfgStopBits     = 2'd1;
        r0 = validRises;
        rx = 1'b0;
        waitCycles(3 * TICK_DIV);
        rx = 1'b1;
        waitCycles(BIT_CYCLES);
        check("false_start_pulses", 32'(validRises - r0), 32'd0);
        check("false_start_busy", 32'(busy), 32'd0);

        // 0x3C with out-of-range cfg (15 data bits -> 8, stop code 3 -> 1)
        cfgDataBits = 4'd15;
        cfgStopBits = 2'd3;
        sendFrame(8'h3C, 8, 1'b0, 1'b0, 1, 1'b0);
        check("3c_pulses", 32'(validRises - r0), 32'd1);
        check("3c_data", 32'(capData), 32'h3C);
        check("3c_frm", 32'(capFrm), 32'd0);
        cfgDataBits = 4'd8;
        cfgStopBits = 2'd1;

        // Break: line low for 20 bit times
        r0 = validRises;
        rx = 1'b0;
        waitCycles(15 * BIT_CYCLES);
        check("brk_pulses_mid", 32'(validRises - r0), 32'd1);
        check("brk_linewait_busy", 32'(busy), 32'd1);
        waitCycles(5 * BIT_CYCLES);
        check("brk_no_new_frame", 32'(validRises - r0), 32'd1);
        rx = 1'b1;
        waitCycles(2 * BIT_CYCLES);
        check("brk_busy_after", 32'(busy), 32'd0);
        check("brk_data", 32'(capData), 32'h00);
        check("brk_brk", 32'(capBrk), 32'd1);
        check("brk_frm", 32'(capFrm), 32'd1);
        check("brk_par", 32'(capPar), 32'd0);

        // Overrun: two frames without draining
        rxReady = 1'b0;
        sendFrame(8'h11, 8, 1'b0, 1'b0, 1, 1'b0);
        check("ovr1_valid", 32'(rxValid), 32'd1);
        check("ovr1_data", 32'(rxData), 32'h11);
        check("ovr1_ovr", 32'(overrunError), 32'd0);
        sendFrame(8'h22, 8, 1'b0, 1'b0, 1, 1'b0);
        check("ovr2_valid", 32'(rxValid), 32'd1);
        check("ovr2_data", 32'(rxData), 32'h22);
        check("ovr2_ovr", 32'(overrunError), 32'd1);
        rxReady = 1'b1;
        waitCycles(1);
        rxReady = 1'b0;
        check("ovr_drain_valid", 32'(rxValid), 32'd0);
        waitCycles(4);
        check("ovr_drain_hold", 32'(rxValid), 32'd0);
        rxReady = 1'b1;

        // Reset during data bit 3 of a 0xFF frame
        r0 = validRises;
        rx = 1'b0;
        waitCycles(BIT_CYCLES);
        rx = 1'b1;
        waitCycles(3 * BIT_CYCLES + BIT_CYCLES / 4);
        check("midrst_busy_before", 32'(busy), 32'd1);
        reset = 1'b0;
        waitCycles(2);
        reset = 1'b1;
        waitCycles(1);
        check("midrst_data", 32'(rxData), 32'h00);
        check("midrst_valid", 32'(rxValid), 32'd0);
        check("midrst_par", 32'(parityError), 32'd0);
        check("midrst_frm", 32'(framingError), 32'd0);
        check("midrst_brk", 32'(breakError), 32'd0);
        check("midrst_ovr", 32'(overrunError), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        waitCycles(6 * BIT_CYCLES);
        check("midrst_no_delivery", 32'(validRises - r0), 32'd0);

        // 0x5A with cfg inputs changed mid-frame
        sendFrame(8'h5A, 8, 1'b0, 1'b0, 1, 1'b1);
        check("5a_pulses", 32'(validRises - r0), 32'd1);
        check("5a_data", 32'(capData), 32'h5A);
        check("5a_par", 32'(capPar), 32'd0);
        check("5a_frm", 32'(capFrm), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
